uart_program_loader: RTL and testbench

//  Receives a program image over UART (8N1, LSB first) and drives the instruction-memory upload port:
//  one 32-bit word write per 4 received bytes, then flags completion so the CPU resumes fetching.

---
 rtl/uart_program_loader_pkg.sv | 29 ++
 rtl/uart_program_loader_rx.sv | 95 +++++++++
 rtl/uart_program_loader.sv | 162 ++++++++++++++++
 tb/tb_uart_program_loader.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_program_loader_pkg.sv
// Shared types and constants for the UART program loader: FSM state encodings
// and the bit-period helper used to size the receiver.
package uart_program_loader_pkg;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_LEN_LO,
    LD_LEN_HI,
    LD_DATA,
    LD_DONE,
    LD_ERR
  } ld_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  localparam int MIN_CLKS_PER_BIT = 4;

  function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
    int c;
    c = clk_freq / baud;
    return (c < MIN_CLKS_PER_BIT) ? MIN_CLKS_PER_BIT : c;
  endfunction

endpackage

// File: rtl/uart_program_loader_rx.sv
// 8N1 UART byte receiver: 2-FF synchronizer, mid-bit sampling, glitch-rejecting
// start detection, one-cycle byte_valid / frame_err pulses.
module uart_rx_byte
  import uart_program_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_o,
  output logic       frame_err_o
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);

  logic             rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        // Edge, not level: a line stuck low after a bad stop bit must not retrigger.
        if (rx_prev_q && !rx_sync_q) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == CNT_W'(HALF_BIT - 1)) begin
          cnt_d   = '0;
          state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (rx_sync_q) valid_d = 1'b1;
          else           ferr_d  = 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_valid_o = valid_q;
  assign byte_o       = shift_q;
  assign frame_err_o  = ferr_q;

endmodule

// File: rtl/uart_program_loader.sv
// Program loader: receives a length-prefixed image over UART and writes it
// word by word into instruction memory through the upload port.
module uart_program_loader
  import uart_program_loader_pkg::*;
#(
  parameter int CLK_FREQ    = 10_000_000,
  parameter int BAUD        = 115200,
  parameter int ADDR_W      = 14,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_en,
  input  logic              rx,
  output logic              upg_wen_o,
  output logic [ADDR_W-1:0] upg_adr_o,
  output logic [31:0]       upg_dat_o,
  output logic              upg_done_o,
  output logic              upg_err_o
);

  localparam int          CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD);
  localparam logic [32:0] MAX_WORDS    = 33'(1) << ADDR_W;

  logic       byte_valid;
  logic [7:0] rx_byte;
  logic       frame_err;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk_i        (clock),
    .rst_i        (reset),
    .rx_i         (rx),
    .byte_valid_o (byte_valid),
    .byte_o       (rx_byte),
    .frame_err_o  (frame_err)
  );

  ld_state_e         state_q, state_d;
  logic              load_en_q;
  logic [15:0]       len_q, len_d;
  logic [15:0]       word_idx_q, word_idx_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [23:0]       buf_q, buf_d;
  logic [31:0]       tmo_q, tmo_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [31:0]       dat_q, dat_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [15:0]       hdr_len;
  logic              tmo_hit;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= LD_IDLE;
      load_en_q  <= 1'b0;
      len_q      <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      buf_q      <= '0;
      tmo_q      <= '0;
      wen_q      <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_en_q  <= load_en;
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      buf_q      <= buf_d;
      tmo_q      <= tmo_d;
      wen_q      <= wen_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign hdr_len = {rx_byte, len_q[7:0]};
  assign tmo_hit = (tmo_q == 32'(TIMEOUT_CYC - 1)) && !byte_valid;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    buf_d      = buf_q;
    tmo_d      = '0;
    wen_d      = 1'b0;
    adr_d      = adr_q;
    dat_d      = dat_q;
    err_d      = err_q;
    // Derived from the registered state so done trails the last strobe by one cycle.
    done_d     = (state_q == LD_DONE) && load_en;

    if ((state_q == LD_LEN_HI || state_q == LD_DATA) && !byte_valid) tmo_d = tmo_q + 1'b1;

    if (!load_en) begin
      state_d    = LD_IDLE;
      byte_idx_d = '0;
    end else begin
      case (state_q)
        LD_IDLE: begin
          if (!load_en_q) begin
            state_d    = LD_LEN_LO;
            err_d      = 1'b0;
            word_idx_d = '0;
            byte_idx_d = '0;
          end
        end
        LD_LEN_LO: begin
          if (frame_err) state_d = LD_ERR;
          else if (byte_valid) begin
            len_d[7:0] = rx_byte;
            state_d    = LD_LEN_HI;
          end
        end
        LD_LEN_HI: begin
          if (frame_err) state_d = LD_ERR;
          else if (byte_valid) begin
            len_d = hdr_len;
            if (hdr_len == 16'd0)                state_d = LD_DONE;
            else if (33'(hdr_len) > MAX_WORDS)   state_d = LD_ERR;
            else                                 state_d = LD_DATA;
          end else if (tmo_hit) state_d = LD_ERR;
        end
        LD_DATA: begin
          if (frame_err) state_d = LD_ERR;
          else if (byte_valid) begin
            if (byte_idx_q == 2'd3) begin
              wen_d      = 1'b1;
              adr_d      = ADDR_W'(word_idx_q);
              dat_d      = {rx_byte, buf_q};
              word_idx_d = word_idx_q + 1'b1;
              byte_idx_d = '0;
              if (word_idx_q == len_q - 16'd1) state_d = LD_DONE;
            end else begin
              buf_d      = {rx_byte, buf_q[23:8]};
              byte_idx_d = byte_idx_q + 1'b1;
            end
          end else if (tmo_hit) state_d = LD_ERR;
        end
        LD_DONE: ;
        LD_ERR:  ;
        default: state_d = LD_IDLE;
      endcase
    end

    if (state_d == LD_ERR) err_d = 1'b1;
  end

  assign upg_wen_o  = wen_q;
  assign upg_adr_o  = adr_q;
  assign upg_dat_o  = dat_q;
  assign upg_done_o = done_q;
  assign upg_err_o  = err_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Scoreboard bench for uart_program_loader with CLKS_PER_BIT = 16 and a
// shortened inter-byte timeout.
module tb_uart_program_loader;

  localparam int ADDR_W = 14;
  localparam int CPB    = 16;
  localparam int TMO    = 3000;
  localparam int W      = ADDR_W + 32;

  logic              clock = 1'b0;
  logic              reset;
  logic              load_en;
  logic              rx;
  logic              upg_wen_o;
  logic [ADDR_W-1:0] upg_adr_o;
  logic [31:0]       upg_dat_o;
  logic              upg_done_o;
  logic              upg_err_o;

  uart_program_loader #(
    .CLK_FREQ    (CPB * 115200),
    .BAUD        (115200),
    .ADDR_W      (ADDR_W),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .load_en    (load_en),
    .rx         (rx),
    .upg_wen_o  (upg_wen_o),
    .upg_adr_o  (upg_adr_o),
    .upg_dat_o  (upg_dat_o),
    .upg_done_o (upg_done_o),
    .upg_err_o  (upg_err_o)
  );

  // clock / reset
  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clock) cyc++;

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_w;
  int           wen_count = 0;
  int           last_wen_cyc = -1;
  int           done_rise_cyc = -1;
  logic         done_prev = 1'b0;
  int           byte_pulses = 0;

  always @(negedge clock) begin
    if (!reset && upg_wen_o) begin
      wen_count++;
      last_wen_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_wen actual adr=%h dat=%h required no strobe", upg_adr_o, upg_dat_o);
      end else begin
        exp_w = exp_q.pop_front();
        if ({upg_adr_o, upg_dat_o} !== exp_w) begin
          failures++;
          $display("FAIL wen_payload actual adr=%h dat=%h required adr=%h dat=%h",
                   upg_adr_o, upg_dat_o, exp_w[W-1:32], exp_w[31:0]);
        end
      end
    end
    if (upg_done_o && !done_prev) done_rise_cyc = cyc;
    done_prev = upg_done_o;
    if (dut.byte_valid) byte_pulses++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // drivers
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clock);
    rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clock);
    end
    rx = stop;
    repeat (CPB) @(negedge clock);
    rx = 1'b1;
    if (!stop) repeat (CPB) @(negedge clock);
  endtask

  task automatic send_bytes(input logic [7:0] bytes[], input int n);
    for (int i = 0; i < n; i++) send_byte(bytes[i], 1'b1);
  endtask

  task automatic wait_done(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (upg_done_o) break;
      @(negedge clock);
    end
    #1;
    check(name, upg_done_o, 1);
  endtask

  task automatic restart_load();
    @(negedge clock);
    load_en = 1'b0;
    wait_cycles(3);
    load_en = 1'b1;
    wait_cycles(3);
  endtask

  int         base;
  logic       bad;
  logic [7:0] seq[];

  initial begin
    reset = 1'b1;
    load_en = 1'b0;
    rx = 1'b1;
    repeat (5) @(negedge clock);
    reset = 1'b0;

    // idle after reset, then a short low glitch on rx
    bad = 1'b0;
    repeat (100) begin
      @(negedge clock);
      if (upg_wen_o || upg_done_o || upg_err_o || (|upg_adr_o) || (|upg_dat_o)) bad = 1'b1;
    end
    check("reset_outputs_zero", bad, 0);
    @(negedge clock);
    rx = 1'b0;
    repeat (6) @(negedge clock);
    rx = 1'b1;
    wait_cycles(200);
    check("glitch_no_byte", byte_pulses, 0);
    check("glitch_no_err", upg_err_o, 0);

    // two-word image
    load_en = 1'b1;
    wait_cycles(3);
    base = wen_count;
    exp_q.push_back({14'd0, 32'h1234_5678});
    exp_q.push_back({14'd1, 32'hDEAD_BEEF});
    seq = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_bytes(seq, 10);
    wait_done("two_word_done", 400);
    check("two_word_done_latency", done_rise_cyc, last_wen_cyc + 1);
    check("two_word_strobes", wen_count - base, 2);
    check("two_word_err", upg_err_o, 0);
    check("two_word_queue_empty", exp_q.size(), 0);
    wait_cycles(20);
    check("done_held", upg_done_o, 1);
    check("adr_held", upg_adr_o, 14'd1);
    load_en = 1'b0;
    wait_cycles(1);
    check("done_clear_on_load_en_fall", upg_done_o, 0);

    // zero-length image
    wait_cycles(3);
    load_en = 1'b1;
    wait_cycles(3);
    base = wen_count;
    seq = '{8'h00, 8'h00};
    send_bytes(seq, 2);
    wait_done("zero_len_done", 400);
    check("zero_len_strobes", wen_count - base, 0);
    load_en = 1'b0;
    wait_cycles(1);
    check("zero_len_done_clear", upg_done_o, 0);

    // oversize header N = 16385
    wait_cycles(3);
    load_en = 1'b1;
    wait_cycles(3);
    base = wen_count;
    seq = '{8'h01, 8'h40};
    send_bytes(seq, 2);
    wait_cycles(20);
    check("oversize_err", upg_err_o, 1);
    check("oversize_done", upg_done_o, 0);
    check("oversize_strobes", wen_count - base, 0);
    load_en = 1'b0;
    wait_cycles(3);
    check("err_sticky_after_load_en_fall", upg_err_o, 1);
    load_en = 1'b1;
    wait_cycles(3);
    check("err_cleared_on_rise", upg_err_o, 0);

    // framing error in data phase
    seq = '{8'h01, 8'h00};
    send_bytes(seq, 2);
    send_byte(8'h55, 1'b0);
    wait_cycles(20);
    check("frame_err", upg_err_o, 1);
    check("frame_err_strobes", wen_count - base, 0);

    // inter-byte timeout, then recovery
    restart_load();
    seq = '{8'h01, 8'h00, 8'hAA, 8'hBB};
    send_bytes(seq, 4);
    check("timeout_not_yet", upg_err_o, 0);
    wait_cycles(TMO + 50);
    check("timeout_err", upg_err_o, 1);
    check("timeout_strobes", wen_count - base, 0);
    restart_load();
    check("timeout_err_cleared", upg_err_o, 0);
    exp_q.push_back({14'd0, 32'hDDCC_BBAA});
    seq = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_bytes(seq, 6);
    wait_done("retransmit_done", 400);
    check("retransmit_err", upg_err_o, 0);
    check("retransmit_strobes", wen_count - base, 1);
    check("retransmit_queue_empty", exp_q.size(), 0);

    // reset in the middle of the second word
    restart_load();
    exp_q.push_back({14'd0, 32'h4433_2211});
    seq = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_bytes(seq, 8);
    check("pre_reset_dat", upg_dat_o, 32'h4433_2211);
    @(negedge clock);
    reset = 1'b1;
    load_en = 1'b0;
    wait_cycles(1);
    check("reset_mid_outputs", {upg_wen_o, upg_done_o, upg_err_o, upg_adr_o, upg_dat_o}, 0);
    reset = 1'b0;
    base = wen_count;
    seq = '{8'h77, 8'h88};
    send_bytes(seq, 2);
    wait_cycles(50);
    check("reset_no_further_strobes", wen_count - base, 0);
    check("reset_queue_empty", exp_q.size(), 0);
    check("reset_done_low", upg_done_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
